// File: rtl/phy_mgmt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : phy_mgmt_pkg
// Purpose  : Shared MDIO register constants, status bit positions, speed
//            encodings and controller state encodings for PHY management.
// Revision : 1.0 - initial release
// ============================================================================
package phy_mgmt_pkg;

    localparam logic [4:0]  REG_BMCR     = 5'd0;
    localparam logic [4:0]  REG_BMSR     = 5'd1;
    localparam logic [15:0] BMCR_RST_AN  = 16'h9000;

    localparam int BMCR_RST_BIT = 15;
    localparam int STAT_SPD_HI  = 15;
    localparam int STAT_SPD_LO  = 14;
    localparam int STAT_DPX     = 13;
    localparam int STAT_LINK    = 10;

    localparam logic [1:0] SPD_10   = 2'b00;
    localparam logic [1:0] SPD_100  = 2'b01;
    localparam logic [1:0] SPD_1000 = 2'b10;

    typedef logic [2:0] fsm_state_t;

    localparam fsm_state_t ST_IDLE       = 3'd0;
    localparam fsm_state_t ST_RST_WR     = 3'd1;
    localparam fsm_state_t ST_RST_WR_RSP = 3'd2;
    localparam fsm_state_t ST_RST_RD     = 3'd3;
    localparam fsm_state_t ST_RST_RD_RSP = 3'd4;
    localparam fsm_state_t ST_POLL_RD    = 3'd5;
    localparam fsm_state_t ST_POLL_RSP   = 3'd6;
    localparam fsm_state_t ST_POLL_WAIT  = 3'd7;

    // A link-down port or the reserved 2'b11 code both report as 10M.
    function automatic logic [1:0] decode_speed(input logic link, input logic [1:0] raw);
        logic [1:0] spd;
        spd = SPD_10;
        if (link && (raw == SPD_100 || raw == SPD_1000)) begin
            spd = raw;
        end
        return spd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/phy_mgmt_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : phy_mgmt_ctrl_if
// Purpose  : Command/response handshake between the PHY management
//            controller (master) and the MDIO station engine (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface phy_mgmt_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [4:0]  cmd_phy_addr;
    logic [4:0]  cmd_reg_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;

    modport master (
        output cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata
    );
endinterface
`default_nettype wire

// File: rtl/phy_poll_timer.sv
`default_nettype none
// ============================================================================
// Module   : phy_poll_timer
// Purpose  : Loadable down-counter; o_expire marks the final cycle of the
//            loaded interval so the caller can act on the following edge.
// Revision : 1.0 - initial release
// ============================================================================
module phy_poll_timer #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_load_val,
    input  wire logic             i_en,
    output logic                  o_expire
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expire = (r_count <= WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/phy_mgmt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : phy_mgmt_ctrl
// Purpose  : Soft-resets each RGMII PHY over MDIO, then polls each PHY's
//            specific-status register forever to drive link/speed/duplex.
// Revision : 1.0 - initial release
// ============================================================================
module phy_mgmt_ctrl
    import phy_mgmt_pkg::*;
#(
    parameter int NUM_PORTS     = 2,
    parameter int PHY_ADDR_BASE = 0,
    parameter int POLL_INTERVAL = 625000,
    parameter int RST_POLL_MAX  = 16,
    parameter int STAT_REG      = 17
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    phy_mgmt_ctrl_if.master             mgmt,
    output logic [NUM_PORTS-1:0]        eth_link_status,
    output logic [2*NUM_PORTS-1:0]      eth_clock_speed,
    output logic [NUM_PORTS-1:0]        eth_duplex_status,
    output logic                        init_done,
    output logic [NUM_PORTS-1:0]        init_error
);

    localparam int         c_PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int         c_TMR_W     = $clog2(POLL_INTERVAL + 1);
    localparam int         c_RTY_W     = $clog2(RST_POLL_MAX + 1);
    localparam logic [c_PORT_W-1:0] c_LAST_PORT = c_PORT_W'(NUM_PORTS - 1);
    localparam logic [c_TMR_W-1:0]  c_TMR_LOAD  = c_TMR_W'(POLL_INTERVAL - 1);
    localparam logic [c_RTY_W-1:0]  c_RTY_MAX   = c_RTY_W'(RST_POLL_MAX);
    localparam logic [4:0] c_ADDR_BASE = 5'(PHY_ADDR_BASE);
    localparam logic [4:0] c_STAT_REG  = 5'(STAT_REG);
    // With a one-cycle interval the next read must follow the response directly.
    localparam bit         c_SKIP_WAIT = (POLL_INTERVAL <= 1);

    fsm_state_t              r_state;
    logic [c_PORT_W-1:0]     r_port;
    logic [c_RTY_W-1:0]      r_retry;
    logic [NUM_PORTS-1:0]    r_link;
    logic [2*NUM_PORTS-1:0]  r_speed;
    logic [NUM_PORTS-1:0]    r_duplex;
    logic                    r_init_done;
    logic [NUM_PORTS-1:0]    r_init_error;

    logic                    w_rsp;
    logic [15:0]             w_rdata;
    logic                    w_last_port;
    logic [c_RTY_W-1:0]      w_retry_nxt;
    logic                    w_link;
    logic [1:0]              w_speed;
    logic                    w_duplex;
    logic                    w_tmr_load;
    logic                    w_tmr_en;
    logic                    w_tmr_expire;
    logic                    w_cmd_valid;
    logic                    w_cmd_write;
    logic [4:0]              w_cmd_reg;
    logic [15:0]             w_cmd_wdata;

    assign w_rsp       = mgmt.rsp_valid;
    assign w_rdata     = mgmt.rsp_rdata;
    assign w_last_port = (r_port == c_LAST_PORT);
    assign w_retry_nxt = r_retry + 1'b1;
    assign w_link      = w_rdata[STAT_LINK];
    assign w_speed     = decode_speed(w_link, w_rdata[STAT_SPD_HI:STAT_SPD_LO]);
    assign w_duplex    = w_link & w_rdata[STAT_DPX];
    assign w_tmr_load  = (r_state == ST_POLL_RSP) && w_rsp && w_last_port;
    assign w_tmr_en    = (r_state == ST_POLL_WAIT);

    phy_poll_timer #(
        .WIDTH (c_TMR_W)
    ) u_poll_timer (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_tmr_load),
        .i_load_val (c_TMR_LOAD),
        .i_en       (w_tmr_en),
        .o_expire   (w_tmr_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_port       <= '0;
            r_retry      <= '0;
            r_link       <= '0;
            r_speed      <= '0;
            r_duplex     <= '0;
            r_init_done  <= 1'b0;
            r_init_error <= '0;
        end else begin
            case (r_state)
                ST_IDLE: r_state <= ST_RST_WR;
                ST_RST_WR: begin
                    if (mgmt.cmd_ready) r_state <= ST_RST_WR_RSP;
                end
                ST_RST_WR_RSP: begin
                    if (w_rsp) begin
                        r_retry <= '0;
                        r_state <= ST_RST_RD;
                    end
                end
                ST_RST_RD: begin
                    if (mgmt.cmd_ready) r_state <= ST_RST_RD_RSP;
                end
                ST_RST_RD_RSP: begin
                    if (w_rsp) begin
                        if (w_rdata[BMCR_RST_BIT]) begin
                            r_retry <= w_retry_nxt;
                        end
                        if (w_rdata[BMCR_RST_BIT] && w_retry_nxt != c_RTY_MAX) begin
                            r_state <= ST_RST_RD;
                        end else begin
                            if (w_rdata[BMCR_RST_BIT]) r_init_error[r_port] <= 1'b1;
                            if (w_last_port) begin
                                r_init_done <= 1'b1;
                                r_port      <= '0;
                                r_state     <= ST_POLL_RD;
                            end else begin
                                r_port  <= r_port + 1'b1;
                                r_state <= ST_RST_WR;
                            end
                        end
                    end
                end
                ST_POLL_RD: begin
                    if (mgmt.cmd_ready) r_state <= ST_POLL_RSP;
                end
                ST_POLL_RSP: begin
                    if (w_rsp) begin
                        for (int p = 0; p < NUM_PORTS; p++) begin
                            if (r_port == c_PORT_W'(p)) begin
                                r_link[p]        <= w_link;
                                r_speed[2*p +: 2] <= w_speed;
                                r_duplex[p]      <= w_duplex;
                            end
                        end
                        if (w_last_port) begin
                            r_port  <= '0;
                            r_state <= c_SKIP_WAIT ? ST_POLL_RD : ST_POLL_WAIT;
                        end else begin
                            r_port  <= r_port + 1'b1;
                            r_state <= ST_POLL_RD;
                        end
                    end
                end
                ST_POLL_WAIT: begin
                    if (w_tmr_expire) r_state <= ST_POLL_RD;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Command fields decode straight from registered state, so they hold while waiting for ready.
    always_comb begin
        w_cmd_valid = 1'b0;
        w_cmd_write = 1'b0;
        w_cmd_reg   = '0;
        w_cmd_wdata = '0;
        case (r_state)
            ST_RST_WR: begin
                w_cmd_valid = 1'b1;
                w_cmd_write = 1'b1;
                w_cmd_reg   = REG_BMCR;
                w_cmd_wdata = BMCR_RST_AN;
            end
            ST_RST_RD: begin
                w_cmd_valid = 1'b1;
                w_cmd_reg   = REG_BMCR;
            end
            ST_POLL_RD: begin
                w_cmd_valid = 1'b1;
                w_cmd_reg   = c_STAT_REG;
            end
            default: ;
        endcase
    end

    assign mgmt.cmd_valid    = w_cmd_valid;
    assign mgmt.cmd_write    = w_cmd_write;
    assign mgmt.cmd_phy_addr = w_cmd_valid ? (c_ADDR_BASE + 5'(r_port)) : 5'd0;
    assign mgmt.cmd_reg_addr = w_cmd_reg;
    assign mgmt.cmd_wdata    = w_cmd_wdata;

    assign eth_link_status   = r_link;
    assign eth_clock_speed   = r_speed;
    assign eth_duplex_status = r_duplex;
    assign init_done         = r_init_done;
    assign init_error        = r_init_error;

endmodule
`default_nettype wire

// File: doc/phy_mgmt_ctrl.md
Name: phy_mgmt_ctrl

Overview:
- Sequences all PHY management traffic through the MDIO station engine over a single command/response handshake.
- After reset, soft-resets each RGMII PHY and waits for the reset to clear.
- Then polls each PHY's specific-status register forever, deriving the per-port link, speed and duplex outputs.
- Sits beside the MDIO engine in top; drives eth_link_status, eth_clock_speed and eth_duplex_status toward nf_core.

Parameters:
- NUM_PORTS, 2: number of PHYs managed; PHY address of port p = PHY_ADDR_BASE + p.
- PHY_ADDR_BASE, 0: 5-bit MDIO address of port 0.
- POLL_INTERVAL, 625000: idle cycles between poll rounds (10 ms at 62.5 MHz); must be >= 1.
- RST_POLL_MAX, 16: BMCR reads allowed per port before declaring reset timeout.
- STAT_REG, 17: PHY-specific status register address. Bit layout: [15:14] speed, [13] duplex, [10] real-time link.

Ports:
- clk  in  1  management clock (core_clk_int domain).
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  out  1  command request to MDIO engine.
- cmd_ready  in  1  engine accepts command this cycle.
- cmd_write  out  1  1 = write, 0 = read.
- cmd_phy_addr  out  5  target PHY address.
- cmd_reg_addr  out  5  target register address.
- cmd_wdata  out  16  write data; 0 for reads.
- rsp_valid  in  1  one-cycle pulse: command complete (read or write).
- rsp_rdata  in  16  read data, valid with rsp_valid.
- eth_link_status  out  NUM_PORTS  per-port link up.
- eth_clock_speed  out  2*NUM_PORTS  port p at [2p+1:2p]; 00 = 10M, 01 = 100M, 10 = 1000M.
- eth_duplex_status  out  NUM_PORTS  per-port full duplex.
- init_done  out  1  reset phase finished; stays high until reset.
- init_error  out  NUM_PORTS  sticky per-port PHY reset timeout.

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; port index 0; timer and retry counters 0.
- Handshake:
  - Command fields stable while cmd_valid = 1.
  - Transfer occurs on the cycle cmd_valid & cmd_ready; cmd_valid drops the next cycle.
  - Exactly one command outstanding at a time.
  - rsp_valid is honoured only in *_RSP states and ignored elsewhere (e.g. a stale response after reset).
- FSM states and transitions:
  - IDLE: goes to RST_WR one cycle after reset release.
  - RST_WR: write BMCR (reg 0) = 16'h9000 (reset + autoneg enable) to port p; on transfer -> RST_WR_RSP.
  - RST_WR_RSP: on rsp_valid -> RST_RD; retry count = 0.
  - RST_RD: read BMCR of port p -> RST_RD_RSP.
  - RST_RD_RSP, on rsp_valid:
    - rdata[15] = 0: go to next port.
    - Else increment retry; if retry == RST_POLL_MAX, set init_error[p] and go to next port; otherwise -> RST_RD.
  - Next-port rule (reset phase): after the last port, set init_done, p = 0 -> POLL_RD. Otherwise p++ -> RST_WR.
  - POLL_RD: read STAT_REG of port p -> POLL_RSP.
  - POLL_RSP: on rsp_valid, update port p status (rules below). If last port: p = 0, load timer = POLL_INTERVAL-1 -> POLL_WAIT. Else p++ -> POLL_RD.
  - POLL_WAIT: decrement timer; at 0 -> POLL_RD. The next round's cmd_valid rises exactly POLL_INTERVAL cycles after the last rsp_valid.
- Status update: link = rdata[10].
  - Link = 0: speed forced to 00, duplex to 0.
  - Link = 1: speed = rdata[15:14], with 11 (reserved) reported as 00; duplex = rdata[13].
  - Status outputs are registered, so they change the cycle after rsp_valid.
  - Only the polled port's fields change; other ports hold their values.
- Ports with init_error set are still polled.
- Reset asserted mid-transaction: immediate async return to reset values, no cmd_valid glitch; the sequence restarts from port 0.
- Counter widths: timer $clog2(POLL_INTERVAL+1); retry $clog2(RST_POLL_MAX+1); port index $clog2(NUM_PORTS), minimum 1 bit.

Decomposition:
- Shared package phy_mgmt_pkg holds:
  - Register constants: REG_BMCR = 0, REG_BMSR = 1, BMCR_RST_AN = 16'h9000.
  - Bit indices: BMCR_RST_BIT = 15, STAT_SPD_HI/LO = 15/14, STAT_DPX = 13, STAT_LINK = 10.
  - Speed encodings: SPD_10/100/1000.
  - FSM state enum.
- One sub-module, phy_poll_timer: loadable down-counter with an expire flag, reusable by other pollers.

Test Plan:
- Engine with cmd_ready = 1 and BMCR rdata = 16'h1140 on the first read -> writes of 16'h9000 to addresses 0 then 1, one BMCR read each, init_done = 1, init_error = 00.
- Port 1 BMCR returns 16'h9140 forever, RST_POLL_MAX = 4 -> exactly 4 reads to addr 1, init_error = 10, polling still starts.
- Poll port 0 with rdata = 16'hAC00 -> link0 = 1, speed[1:0] = 10, duplex0 = 1. Poll port 1 with 16'h0000 -> link1 = 0, speed[3:2] = 00.
- Port 0 rdata = 16'hE400 (speed 11) -> speed 00, link 1. Then rdata = 16'h8000 (link down) -> speed 00, duplex 0.
- cmd_ready held low 7 cycles -> cmd_valid and all fields stable for 7 cycles. A spurious rsp_valid during POLL_WAIT -> no status change.
- POLL_INTERVAL = 20 -> round-start cmd_valid exactly 20 cycles after the last rsp_valid. Reset pulsed during POLL_RSP -> all outputs 0 and the sequence restarts with a BMCR write to addr 0.
